// File: rtl/ticket_vend_ctrl.sv
// Platform-ticket vending controller: coin credit against PRICE, ticket handshake, greedy change/refund.
// Optional sales counter output enabled with `define VEND_SALES_CNT_EN.
module ticket_vend_ctrl #(
   parameter int PRICE    = 15,
   parameter int CREDIT_W = 5
`ifdef VEND_SALES_CNT_EN
   ,
   parameter int SALES_W  = 16
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                ticket_ready,
   input  logic                change_ready,
`ifdef VEND_SALES_CNT_EN
   output logic [SALES_W-1:0]  sales_cnt,
`endif
   output logic [CREDIT_W-1:0] credit,
   output logic                ticket_valid,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   output logic                coin_reject,
   output logic                busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_VEND    = 3'd2,
      ST_CHANGE  = 3'd3,
      ST_REFUND  = 3'd4
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
      logic [CREDIT_W-1:0] v;
      case (c)
         2'b00:   v = CREDIT_W'(1);
         2'b01:   v = CREDIT_W'(5);
         2'b10:   v = CREDIT_W'(10);
         default: v = ZERO_C;
      endcase
      return v;
   endfunction

   function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
      logic [1:0] c;
      if (amt >= CREDIT_W'(10)) begin
         c = 2'b10;
      end else if (amt >= CREDIT_W'(5)) begin
         c = 2'b01;
      end else begin
         c = 2'b00;
      end
      return c;
   endfunction

   state_t              state_r, state_s;
   logic [CREDIT_W-1:0] credit_r, credit_s;
   logic                ticket_valid_r, ticket_valid_s;
   logic                change_valid_r, change_valid_s;
   logic [1:0]          change_coin_r, change_coin_s;
   logic                coin_reject_r, coin_reject_s;
   logic                busy_r, busy_s;
   logic [CREDIT_W-1:0] add_s, tick_rem_s, chg_rem_s;

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         credit_r       <= ZERO_C;
         ticket_valid_r <= 1'b0;
         change_valid_r <= 1'b0;
         change_coin_r  <= 2'b00;
         coin_reject_r  <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         credit_r       <= credit_s;
         ticket_valid_r <= ticket_valid_s;
         change_valid_r <= change_valid_s;
         change_coin_r  <= change_coin_s;
         coin_reject_r  <= coin_reject_s;
         busy_r         <= busy_s;
      end
   end

   // Next-state and next-output logic; credit decisions use the post-add/post-subtract value
   always_comb begin
      state_s        = state_r;
      credit_s       = credit_r;
      ticket_valid_s = ticket_valid_r;
      change_valid_s = change_valid_r;
      change_coin_s  = change_coin_r;
      coin_reject_s  = 1'b0;
      busy_s         = busy_r;
      add_s          = credit_r + coin_value(coin);
      tick_rem_s     = credit_r - PRICE_C;
      chg_rem_s      = credit_r - coin_value(change_coin_r);

      case (state_r)
         ST_IDLE, ST_COLLECT: begin
            if (cancel && (state_r == ST_COLLECT) && (credit_r != ZERO_C)) begin
               // cancel beats a simultaneous coin: the coin goes back, credit is refunded
               state_s        = ST_REFUND;
               change_valid_s = 1'b1;
               change_coin_s  = greedy_coin(credit_r);
               busy_s         = 1'b1;
               coin_reject_s  = coin_valid;
            end else if (coin_valid && (coin != 2'b11)) begin
               credit_s = add_s;
               if (add_s >= PRICE_C) begin
                  state_s        = ST_VEND;
                  ticket_valid_s = 1'b1;
                  busy_s         = 1'b1;
               end else begin
                  state_s = ST_COLLECT;
               end
            end else begin
               coin_reject_s = coin_valid;
            end
         end
         ST_VEND: begin
            coin_reject_s = coin_valid;
            if (ticket_ready) begin
               credit_s       = tick_rem_s;
               ticket_valid_s = 1'b0;
               if (tick_rem_s != ZERO_C) begin
                  state_s        = ST_CHANGE;
                  change_valid_s = 1'b1;
                  change_coin_s  = greedy_coin(tick_rem_s);
               end else begin
                  state_s = ST_IDLE;
                  busy_s  = 1'b0;
               end
            end else begin
               state_s = ST_VEND;
            end
         end
         ST_CHANGE, ST_REFUND: begin
            coin_reject_s = coin_valid;
            if (change_ready) begin
               credit_s = chg_rem_s;
               if (chg_rem_s == ZERO_C) begin
                  state_s        = ST_IDLE;
                  change_valid_s = 1'b0;
                  change_coin_s  = 2'b00;
                  busy_s         = 1'b0;
               end else begin
                  change_coin_s = greedy_coin(chg_rem_s);
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s        = ST_IDLE;
            credit_s       = ZERO_C;
            ticket_valid_s = 1'b0;
            change_valid_s = 1'b0;
            change_coin_s  = 2'b00;
            busy_s         = 1'b0;
         end
      endcase
   end

   assign credit       = credit_r;
   assign ticket_valid = ticket_valid_r;
   assign change_valid = change_valid_r;
   assign change_coin  = change_coin_r;
   assign coin_reject  = coin_reject_r;
   assign busy         = busy_r;

`ifdef VEND_SALES_CNT_EN
   logic [SALES_W-1:0] sales_cnt_r;

   // Completed-sale counter, wraps naturally; refunds never touch it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sales_cnt_r <= {SALES_W{1'b0}};
      end else if ((state_r == ST_VEND) && ticket_valid_r && ticket_ready) begin
         sales_cnt_r <= sales_cnt_r + {{(SALES_W-1){1'b0}}, 1'b1};
      end else begin
         sales_cnt_r <= sales_cnt_r;
      end
   end

   assign sales_cnt = sales_cnt_r;
`endif

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Directed self-checking bench for ticket_vend_ctrl at PRICE=15, CREDIT_W=5.
// Observation vector: {credit, ticket_valid, change_valid, change_coin, coin_reject, busy}.
module tb_ticket_vend_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       cancel = 1'b0;
   logic       ticket_ready = 1'b0;
   logic       change_ready = 1'b0;
   logic [4:0] credit;
   logic       ticket_valid, change_valid, coin_reject, busy;
   logic [1:0] change_coin;
`ifdef VEND_SALES_CNT_EN
   logic [15:0] sales_cnt;
   int          exp_sales = 0;
`endif

   int          tests_run = 0;
   int          fail_cnt  = 0;
   logic [10:0] exp_v;

   ticket_vend_ctrl #(.PRICE(15), .CREDIT_W(5)) dut (
      .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
      .ticket_ready(ticket_ready), .change_ready(change_ready),
`ifdef VEND_SALES_CNT_EN
      .sales_cnt(sales_cnt),
`endif
      .credit(credit), .ticket_valid(ticket_valid), .change_valid(change_valid),
      .change_coin(change_coin), .coin_reject(coin_reject), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] obs();
      return {credit, ticket_valid, change_valid, change_coin, coin_reject, busy};
   endfunction

   function automatic logic [10:0] pk(int c, bit tv, bit cv, logic [1:0] cc, bit rej, bit bz);
      return {5'(c), tv, cv, cc, rej, bz};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input logic [1:0] c);
      coin_valid = 1'b1;
      coin       = c;
      step();
      coin_valid = 1'b0;
      coin       = 2'b00;
   endtask

   task automatic test_reset();
      #1;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL reset_hold: got %b want %b", obs(), exp_v); end
      step(); step();
      rst = 1'b0;
      step();
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL reset_release: got %b want %b", obs(), exp_v); end
`ifdef VEND_SALES_CNT_EN
      tests_run++; if (sales_cnt !== 16'd0) begin fail_cnt++; $display("FAIL reset_sales: got %0d want 0", sales_cnt); end
`endif
   endtask

   task automatic test_sale_pennies();
      put_coin(2'b00);
      exp_v = pk(1, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_penny: got %b want %b", obs(), exp_v); end
      put_coin(2'b01);
      exp_v = pk(6, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_nickel: got %b want %b", obs(), exp_v); end
      put_coin(2'b00);
      exp_v = pk(7, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_penny2: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      exp_v = pk(17, 1, 0, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_dime_vend: got %b want %b", obs(), exp_v); end
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      exp_v = pk(2, 0, 1, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_ticket_hs: got %b want %b", obs(), exp_v); end
      change_ready = 1'b1;
      step();
      exp_v = pk(1, 0, 1, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_change1: got %b want %b", obs(), exp_v); end
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL s1_change2_idle: got %b want %b", obs(), exp_v); end
`ifdef VEND_SALES_CNT_EN
      tests_run++; if (sales_cnt !== 16'(exp_sales)) begin fail_cnt++; $display("FAIL s1_sales: got %0d want %0d", sales_cnt, exp_sales); end
`endif
   endtask

   task automatic test_two_dimes();
      put_coin(2'b10);
      exp_v = pk(10, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL d2_dime1: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      exp_v = pk(20, 1, 0, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL d2_dime2_vend: got %b want %b", obs(), exp_v); end
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      exp_v = pk(5, 0, 1, 2'b01, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL d2_change_nickel: got %b want %b", obs(), exp_v); end
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL d2_idle: got %b want %b", obs(), exp_v); end
`ifdef VEND_SALES_CNT_EN
      tests_run++; if (sales_cnt !== 16'(exp_sales)) begin fail_cnt++; $display("FAIL d2_sales: got %0d want %0d", sales_cnt, exp_sales); end
`endif
   endtask

   task automatic test_reject();
      put_coin(2'b00);
      put_coin(2'b01);
      put_coin(2'b11);
      exp_v = pk(6, 0, 0, 2'b00, 1, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rej_invalid: got %b want %b", obs(), exp_v); end
      step();
      exp_v = pk(6, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rej_pulse_end: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      put_coin(2'b10);
      exp_v = pk(16, 1, 0, 2'b00, 1, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rej_in_vend: got %b want %b", obs(), exp_v); end
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      exp_v = pk(1, 0, 1, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rej_vend_hs: got %b want %b", obs(), exp_v); end
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rej_idle: got %b want %b", obs(), exp_v); end
   endtask

   task automatic test_cancel();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_idle_ignored: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      put_coin(2'b00);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      exp_v = pk(11, 0, 1, 2'b10, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_refund_dime: got %b want %b", obs(), exp_v); end
      change_ready = 1'b1;
      step();
      exp_v = pk(1, 0, 1, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_refund_penny: got %b want %b", obs(), exp_v); end
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_idle: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      put_coin(2'b00);
      cancel     = 1'b1;
      coin_valid = 1'b1;
      coin       = 2'b01;
      step();
      cancel     = 1'b0;
      coin_valid = 1'b0;
      coin       = 2'b00;
      exp_v = pk(11, 0, 1, 2'b10, 1, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_coin_same_cycle: got %b want %b", obs(), exp_v); end
      change_ready = 1'b1;
      step();
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL cancel_coin_drained: got %b want %b", obs(), exp_v); end
`ifdef VEND_SALES_CNT_EN
      tests_run++; if (sales_cnt !== 16'(exp_sales)) begin fail_cnt++; $display("FAIL cancel_sales: got %0d want %0d", sales_cnt, exp_sales); end
`endif
   endtask

   task automatic test_stall();
      put_coin(2'b01);
      put_coin(2'b01);
      put_coin(2'b01);
      for (int i = 0; i < 5; i++) begin
         step();
         exp_v = pk(15, 1, 0, 2'b00, 0, 1);
         tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL stall_ticket_%0d: got %b want %b", i, obs(), exp_v); end
      end
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL stall_exact_price_idle: got %b want %b", obs(), exp_v); end
      put_coin(2'b10);
      put_coin(2'b10);
      put_coin(2'b00);
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      for (int i = 0; i < 3; i++) begin
         step();
         exp_v = pk(5, 0, 1, 2'b01, 0, 1);
         tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL stall_change_%0d: got %b want %b", i, obs(), exp_v); end
      end
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL stall_change_done: got %b want %b", obs(), exp_v); end
   endtask

   task automatic test_reset_mid_change();
      put_coin(2'b10);
      put_coin(2'b10);
      ticket_ready = 1'b1;
      step();
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      rst = 1'b1;
      #1;
      exp_v = pk(0, 0, 0, 2'b00, 0, 0);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rst_async_clear: got %b want %b", obs(), exp_v); end
`ifdef VEND_SALES_CNT_EN
      exp_sales = 0;
      tests_run++; if (sales_cnt !== 16'd0) begin fail_cnt++; $display("FAIL rst_sales_clear: got %0d want 0", sales_cnt); end
`endif
      step();
      rst = 1'b0;
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rst_no_stale_change: got %b want %b", obs(), exp_v); end
      for (int i = 1; i <= 14; i++) begin
         put_coin(2'b00);
         exp_v = pk(i, 0, 0, 2'b00, 0, 0);
         tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rst_penny_%0d: got %b want %b", i, obs(), exp_v); end
      end
      put_coin(2'b00);
      exp_v = pk(15, 1, 0, 2'b00, 0, 1);
      tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rst_penny_15_vend: got %b want %b", obs(), exp_v); end
      ticket_ready = 1'b1;
      step();
`ifdef VEND_SALES_CNT_EN
      exp_sales++;
`endif
      for (int i = 0; i < 3; i++) begin
         exp_v = pk(0, 0, 0, 2'b00, 0, 0);
         tests_run++; if (obs() !== exp_v) begin fail_cnt++; $display("FAIL rst_single_vend_%0d: got %b want %b", i, obs(), exp_v); end
         step();
      end
      ticket_ready = 1'b0;
`ifdef VEND_SALES_CNT_EN
      tests_run++; if (sales_cnt !== 16'(exp_sales)) begin fail_cnt++; $display("FAIL rst_sales_after: got %0d want %0d", sales_cnt, exp_sales); end
`endif
   endtask

   initial begin
      test_reset();
      test_sale_pennies();
      test_two_dimes();
      test_reject();
      test_cancel();
      test_stall();
      test_reset_mid_change();
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
